// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: main-decode FSM, ALU decode and PC-enable logic.
// Stalls on mem_ready in FETCH/MEMRD/MEMWR; illegal instructions trap or fall back to FETCH.
module mc_ctrl_fsm #(
  parameter logic MEM_WAIT_EN     = 1'b1,
  parameter logic EN_BNE          = 1'b1,
  parameter logic EN_LOGIC_IMM    = 1'b1,
  parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       immext,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_ALUWB  = 4'd7,
    S_BEQ     = 4'd8,  S_BNE     = 4'd9,  S_ADDIEX = 4'd10, S_LOGIEX = 4'd11,
    S_IMMWB   = 4'd12, S_JUMP    = 4'd13, S_TRAP   = 4'd14
  } state_t;

  state_t     state_q, state_d, state_v;
  logic       mem_ok, funct_ok, op_ok;
  logic [2:0] rtype_alu;

  assign mem_ok  = MEM_WAIT_EN ? mem_ready : 1'b1;
  // While reset is held the outputs present FETCH values, whatever state_q holds.
  assign state_v = reset ? state_q : S_FETCH;
  assign state_o = state_v;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    funct_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_RTYPE:                           op_ok = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      OP_BNE:                             op_ok = EN_BNE;
      OP_ANDI, OP_ORI:                    op_ok = EN_LOGIC_IMM;
      default:                            op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_v;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    pcen       = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    immext     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    illegal    = 1'b0;
    case (state_v)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = mem_ok;
        pcen       = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        if (!op_ok) begin
          state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW:    state_d = S_MEMADR;
            OP_RTYPE:        state_d = S_RTYPEEX;
            OP_BEQ:          state_d = S_BEQ;
            OP_BNE:          state_d = S_BNE;
            OP_ADDI:         state_d = S_ADDIEX;
            OP_ANDI, OP_ORI: state_d = S_LOGIEX;
            OP_J:            state_d = S_JUMP;
            default:         state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe stays up for the whole wait so memory sees a stable request.
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = (state_v == S_BEQ) ? zero : ~zero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = S_IMMWB;
      end
      S_LOGIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        immext     = 1'b1;
        alucontrol = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        state_d    = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
    end
  end

endmodule
